mlp_layer_engine: RTL
=====================

// Module: mlp_layer_engine
// PURPOSE
//  Parametrised single-layer MLP engine: computes y = W*x + b for OUT_DIM outputs over IN_DIM int8 inputs.
//  Loads bias, weights, ifmap from one 32-bit valid/ready stream into local buffers.
//  Runs LANES parallel MAC lanes, then streams results out: requantised int8 or raw 32-bit accumulators.
//  Sits between the DRAM stream interface and the output GLB. Replaces the fixed 8x8 array/PPU top with run-time mode/ReLU.
// PARAMETERS
//  IN_DIM    64  input vector length; multiple of 4 (elaboration $error otherwise)
//  OUT_DIM   64  output vector length; multiple of LANES (elaboration $error otherwise)
//  LANES     8   parallel MAC lanes = outputs computed per group
//  ACC_W     32  accumulator / bias width
//  SHIFT_W   6   requant shift width
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        begin a layer; sampled only in IDLE
//  cfg_raw    in   1        0: int8 requant output; 1: raw ACC_W accumulator output; latched on start
//  cfg_relu   in   1        clamp negatives to 0 in requant mode; latched on start
//  cfg_shift  in   SHIFT_W  arithmetic right-shift amount; latched on start
//  in_valid   in   1        load stream valid
//  in_ready   out  1        load stream ready
//  in_data    in   32       load word
//  out_valid  out  1        result valid
//  out_ready  in   1        result ready
//  out_data   out  32       result: {24{sign}, int8} in requant mode, raw acc in raw mode
//  busy       out  1        high in any state other than IDLE
//  done       out  1        one-cycle pulse after the last output handshake
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid, busy, done = 0; out_data = 0; counters = 0. Buffers not cleared.
//  FSM: IDLE -start-> LD_B -> LD_W -> LD_X -> MAC -> DRAIN -> (next group ? MAC : FIN) -> IDLE.
//  - LD_B: OUT_DIM words, bias[o] = in_data.
//  - LD_W: IN_DIM*OUT_DIM/4 words, output-major. Byte j of word n is W[o][k], with o = (4n+j)/IN_DIM,
//    k = (4n+j)%IN_DIM, and byte 0 = in_data[7:0].
//  - LD_X: IN_DIM/4 words, same byte packing.
//  - in_ready = 1 only in LD_*. A word is consumed on in_valid&&in_ready. Next state is entered the cycle after the last word.
//  - MAC: entry cycle loads acc[l] = bias[g*LANES+l]. Then, for IN_DIM cycles:
//    acc[l] += sext(W[g*LANES+l][k]) * sext(x[k]). Accumulation wraps mod 2^ACC_W (no saturation).
//  - DRAIN: emits lanes 0..LANES-1 in order, one per out handshake.
//    out_valid rises the cycle after the MAC ends. out_data stays stable while out_valid && !out_ready.
//    Back-to-back handshakes give one result per cycle.
//  - FIN: done=1 for exactly one cycle, then IDLE. busy falls in the same cycle done pulses.
//  Requant (cfg_raw=0): t = (acc + (shift?1<<(shift-1):0)) >>> shift, computed ACC_W+1 wide to avoid overflow.
//    Then clamp to [-128,127], or [0,127] when cfg_relu.
//  Requant with shift=0: no rounding term is added.
//  Latency per group: 1 + IN_DIM cycles MAC, plus >= LANES cycles DRAIN.
//  Boundaries:
//  - start while busy: ignored.
//  - start and in_valid in the same IDLE cycle: the word is not consumed.
//  - in_valid deasserted mid-load: FSM holds; counters do not advance.
//  - out_ready low indefinitely: engine stalls in DRAIN; no result is lost or duplicated.
//  - Last word of a segment: counter wraps to 0 when the FSM advances.
//  - rst_n asserted mid-operation: immediate return to reset values. No done pulse. The partial layer is discarded.
//  - cfg_* changes after start: no effect until the next start.
// STRUCTURE
//  Package mlp_pkg:
//  - state_e {IDLE,LD_B,LD_W,LD_X,MAC,DRAIN,FIN}
//  - INT8_MAX / INT8_MIN localparams
//  - function pack_idx(word,byte)
//  Sub-module mlp_requant: combinational round/shift/clamp/ReLU.
//  - Inputs: acc, shift, relu, raw. Output: 32-bit out_data.
//  - Instanced once on the selected drain lane.
//  Buffers are inferred register arrays (bias ACC_W x OUT_DIM, W 8 x IN_DIM*OUT_DIM, x 8 x IN_DIM).
// TESTING (bench params IN_DIM=8, OUT_DIM=8, LANES=4 unless noted)
//  1 Identity test:
//    - Setup: W=I, x=1..8, b=0, shift=0, requant mode.
//    - Expect: out_data = 1..8 in order, then a single done pulse.
//  2 Rounding and clamp:
//    - Setup: b = {100, -300, 5, -5}, W=0, shift=1, relu=0.
//    - Expect: outputs 50, -128, 3, -2.
//    - With relu=1: outputs 50, 0, 3, 0.
//  3 Raw mode:
//    - Setup: W all 127, x all -128, b = 7, cfg_raw=1.
//    - Expect: every output = 7 - 8*16256 = -130041 as 32-bit two's complement.
//  4 Backpressure:
//    - Stimulus: out_ready random 30%; in_valid random 50%.
//    - Expect: results bit-identical to the no-stall run; out_data stable while out_valid && !out_ready.
//  5 Reset mid-MAC:
//    - Stimulus: assert rst_n low at MAC cycle 3, then run a fresh layer.
//    - Expect: out_valid=0 and busy=0 immediately; no done pulse; the fresh layer gives correct results.
//  6 Protocol edges:
//    - Stimulus: start pulsed during LD_W.
//    - Expect: ignored; the layer completes normally and exactly IN_DIM*OUT_DIM/4 weight words are accepted.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and helpers for the single-layer MLP engine.
package mlp_pkg;

   typedef enum logic [2:0] {IDLE, LD_B, LD_W, LD_X, MAC, DRAIN, FIN} state_e;

   localparam int INT8_MAX = 127;
   localparam int INT8_MIN = -128;

   // Flat element index of byte byte_sel inside load word number word.
   function automatic int pack_idx(input int word, input int byte_sel);
      return 4 * word + byte_sel;
   endfunction

endpackage

// File: rtl/mlp_requant.sv
// Combinational result formatter: raw accumulator pass-through or
// rounded arithmetic shift, optional ReLU and int8 saturation.
module mlp_requant
   import mlp_pkg::*;
#(
   parameter int ACC_W   = 32,
   parameter int SHIFT_W = 6
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic [SHIFT_W-1:0]       shift,
   input  logic                     relu,
   input  logic                     raw,
   output logic [31:0]              out_data
);

   localparam int EXT_W = ACC_W + 1;
   localparam logic signed [EXT_W-1:0] Q_HI   = EXT_W'(INT8_MAX);
   localparam logic signed [EXT_W-1:0] Q_LO   = EXT_W'(INT8_MIN);
   localparam logic signed [EXT_W-1:0] Q_ZERO = '0;

   // One extra bit so adding the half-LSB rounding term cannot overflow.
   function automatic logic signed [EXT_W-1:0] round_shift(
      input logic signed [ACC_W-1:0] a,
      input logic [SHIFT_W-1:0]      sh
   );
      logic signed [EXT_W-1:0] ext;
      logic signed [EXT_W-1:0] rnd;
      ext = {a[ACC_W-1], a};
      rnd = '0;
      if (sh != '0) rnd = EXT_W'(1) << (sh - SHIFT_W'(1));
      return (ext + rnd) >>> sh;
   endfunction

   function automatic logic [7:0] sat8(
      input logic signed [EXT_W-1:0] t,
      input logic                    r
   );
      if (r && (t < Q_ZERO)) return 8'd0;
      if (t > Q_HI) return 8'(INT8_MAX);
      if (t < Q_LO) return 8'(INT8_MIN);
      return t[7:0];
   endfunction

   logic [7:0] q;

   always_comb begin
      q = sat8(round_shift(acc, shift), relu);
      if (raw) out_data = 32'(acc);
      else     out_data = {{24{q[7]}}, q};
   end

endmodule

// File: rtl/mlp_layer_engine.sv
// Single-layer MLP engine: streams in bias/weights/ifmap, computes y = W*x + b
// LANES outputs at a time, and drains requantised or raw results.
module mlp_layer_engine
   import mlp_pkg::*;
#(
   parameter int IN_DIM  = 64,
   parameter int OUT_DIM = 64,
   parameter int LANES   = 8,
   parameter int ACC_W   = 32,
   parameter int SHIFT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               cfg_raw,
   input  logic               cfg_relu,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_data,
   output logic               busy,
   output logic               done
);

   localparam int W_WORDS = IN_DIM * OUT_DIM / 4;
   localparam int X_WORDS = IN_DIM / 4;
   localparam int GROUPS  = OUT_DIM / LANES;
   localparam int CNT_MAX = (W_WORDS > IN_DIM + 1) ? W_WORDS : IN_DIM + 1;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int B_W     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam int WI_W    = $clog2(IN_DIM * OUT_DIM);
   localparam int X_W     = $clog2(IN_DIM);
   localparam int G_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int L_W     = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [CNT_W-1:0] B_LAST   = CNT_W'(OUT_DIM - 1);
   localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(W_WORDS - 1);
   localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(X_WORDS - 1);
   localparam logic [CNT_W-1:0] MAC_LAST = CNT_W'(IN_DIM);
   localparam logic [G_W-1:0]   G_LAST   = G_W'(GROUPS - 1);
   localparam logic [L_W-1:0]   L_LAST   = L_W'(LANES - 1);

   if (IN_DIM % 4 != 0) begin : g_bad_in_dim
      $error("mlp_layer_engine: IN_DIM must be a multiple of 4");
   end
   if (OUT_DIM % LANES != 0) begin : g_bad_out_dim
      $error("mlp_layer_engine: OUT_DIM must be a multiple of LANES");
   end

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [G_W-1:0]     g_q;
   logic [L_W-1:0]     lane_q;
   logic               in_ready_q, out_valid_q, busy_q, done_q;
   logic               cfg_raw_q, cfg_relu_q;
   logic [SHIFT_W-1:0] cfg_shift_q;

   logic signed [ACC_W-1:0] bias_buf [OUT_DIM];
   logic signed [7:0]       w_buf    [IN_DIM*OUT_DIM];
   logic signed [7:0]       x_buf    [IN_DIM];
   logic signed [ACC_W-1:0] lane_acc [LANES];

   logic        in_fire, out_fire;
   logic [31:0] rq_data;

   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = out_valid_q && out_ready;

   // Control: FSM, counters and registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         g_q         <= '0;
         lane_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_raw_q   <= 1'b0;
         cfg_relu_q  <= 1'b0;
         cfg_shift_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= LD_B;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b1;
                  cnt_q       <= '0;
                  g_q         <= '0;
                  lane_q      <= '0;
                  cfg_raw_q   <= cfg_raw;
                  cfg_relu_q  <= cfg_relu;
                  cfg_shift_q <= cfg_shift;
               end
            end
            LD_B: begin
               if (in_fire) begin
                  if (cnt_q == B_LAST) begin
                     cnt_q   <= '0;
                     state_q <= LD_W;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            LD_W: begin
               if (in_fire) begin
                  if (cnt_q == W_LAST) begin
                     cnt_q   <= '0;
                     state_q <= LD_X;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            LD_X: begin
               if (in_fire) begin
                  if (cnt_q == X_LAST) begin
                     cnt_q      <= '0;
                     in_ready_q <= 1'b0;
                     state_q    <= MAC;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            MAC: begin
               // cnt 0 seeds the accumulators with bias; cnt 1..IN_DIM accumulate k = cnt-1.
               if (cnt_q == MAC_LAST) begin
                  cnt_q       <= '0;
                  lane_q      <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= DRAIN;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (out_fire) begin
                  if (lane_q == L_LAST) begin
                     lane_q      <= '0;
                     out_valid_q <= 1'b0;
                     if (g_q == G_LAST) begin
                        g_q     <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FIN;
                     end else begin
                        g_q     <= g_q + G_W'(1);
                        state_q <= MAC;
                     end
                  end else begin
                     lane_q <= lane_q + L_W'(1);
                  end
               end
            end
            FIN:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Load buffers: plain storage, never reset.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         case (state_q)
            LD_B: bias_buf[cnt_q[B_W-1:0]] <= ACC_W'($signed(in_data));
            LD_W: begin
               for (int j = 0; j < 4; j++)
                  w_buf[WI_W'(pack_idx(int'(cnt_q), j))] <= 8'(in_data >> (8 * j));
            end
            LD_X: begin
               for (int j = 0; j < 4; j++)
                  x_buf[X_W'(pack_idx(int'(cnt_q), j))] <= 8'(in_data >> (8 * j));
            end
            default: ;
         endcase
      end
   end

   logic [X_W-1:0] k_idx;
   assign k_idx = X_W'(cnt_q - CNT_W'(1));

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [ACC_W-1:0] acc_q;
      logic signed [15:0]      prod;
      logic [B_W-1:0]          b_idx;
      logic [WI_W-1:0]         w_idx;

      assign b_idx = B_W'(int'(g_q) * LANES + l);
      assign w_idx = WI_W'((int'(g_q) * LANES + l) * IN_DIM + int'(k_idx));
      assign prod  = w_buf[w_idx] * x_buf[k_idx];

      always_ff @(posedge clk) begin
         if (state_q == MAC) begin
            if (cnt_q == '0) acc_q <= bias_buf[b_idx];
            else             acc_q <= acc_q + {{(ACC_W-16){prod[15]}}, prod};
         end
      end

      assign lane_acc[l] = acc_q;
   end

   mlp_requant #(
      .ACC_W   (ACC_W),
      .SHIFT_W (SHIFT_W)
   ) u_requant (
      .acc      (lane_acc[lane_q]),
      .shift    (cfg_shift_q),
      .relu     (cfg_relu_q),
      .raw      (cfg_raw_q),
      .out_data (rq_data)
   );

   assign out_data  = out_valid_q ? rq_data : '0;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
